// File: rtl/mul_iter.sv
// Iterative multiplier feeding the 64-bit ALU operand inputs (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL).
// Retires BITS_PER_CYCLE multiplier bits per cycle and stops once the remaining multiplier bits are pure extension.
module mul_iter #(
  parameter int BITS_PER_CYCLE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        mul_long,
  input  logic        mul_signed,
  input  logic        mul_acc,
  input  logic [31:0] rm,
  input  logic [31:0] rs,
  input  logic [31:0] acc_lo,
  input  logic [31:0] acc_hi,
  output logic        busy,
  output logic        done,
  output logic [63:0] alu_op1,
  output logic [63:0] alu_op2
);

  localparam int B = BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [63:0]        mcand;
  logic [63:0]        p;
  logic [63:0]        prod;
  logic [63:0]        p_next;
  logic [31:0]        rs_sh;
  logic [31:0]        rs_rem;
  logic signed [31:0] rs_sra;
  logic [B-1:0]       chunk;
  logic               long_r;
  logic               signed_r;
  logic               acc_r;
  logic [31:0]        acc_lo_r;
  logic [31:0]        acc_hi_r;
  logic               launch;
  logic               rem_neg;
  logic               finish;

  // The multiplicand is pre-shifted and the multiplier consumed from the bottom,
  // so each iteration works on fixed bit positions instead of variable shifts.
  assign chunk   = rs_sh[B-1:0];
  assign rs_sra  = $signed(rs_sh) >>> B;
  assign rs_rem  = signed_r ? $unsigned(rs_sra) : (rs_sh >> B);
  assign rem_neg = signed_r && (rs_rem == 32'hFFFF_FFFF);
  assign finish  = (rs_rem == 32'h0) || rem_neg;
  assign prod    = mcand * 64'(chunk);
  assign launch  = ((state == IDLE) || (state == DONE)) && start && !abort;

  // An all-ones remainder means the chunks so far were read as unsigned but the
  // multiplier is negative: subtract the weight of the bit just above them.
  always_comb begin
    p_next = p + prod;
    if (rem_neg) begin
      p_next = p_next - (mcand << B);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (launch) state_next = RUN;
      end
      RUN: begin
        if (abort)       state_next = IDLE;
        else if (finish) state_next = DONE;
      end
      DONE: begin
        if (launch) state_next = RUN;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= 64'h0;
      p        <= 64'h0;
      rs_sh    <= 32'h0;
      long_r   <= 1'b0;
      signed_r <= 1'b0;
      acc_r    <= 1'b0;
      acc_lo_r <= 32'h0;
      acc_hi_r <= 32'h0;
      alu_op1  <= 64'h0;
      alu_op2  <= 64'h0;
    end else if (launch) begin
      mcand    <= (mul_signed && mul_long) ? {{32{rm[31]}}, rm} : {32'h0, rm};
      p        <= 64'h0;
      rs_sh    <= rs;
      long_r   <= mul_long;
      signed_r <= mul_signed && mul_long;
      acc_r    <= mul_acc;
      acc_lo_r <= acc_lo;
      acc_hi_r <= acc_hi;
    end else if ((state == RUN) && !abort) begin
      p     <= p_next;
      mcand <= mcand << B;
      rs_sh <= rs_rem;
      if (finish) begin
        alu_op1 <= long_r ? p_next : {32'h0, p_next[31:0]};
        if (!acc_r)      alu_op2 <= 64'h0;
        else if (long_r) alu_op2 <= {acc_hi_r, acc_lo_r};
        else             alu_op2 <= {32'h0, acc_lo_r};
      end
    end
  end

endmodule

// File: doc/mul_iter.md
# mul_iter

Iterative multiplier that sits directly upstream of the 64-bit ALU operand inputs. It executes MUL, MLA, UMULL, UMLAL, SMULL and SMLAL. It retires BITS_PER_CYCLE multiplier bits per clock and stops early once the remaining bits of `rs` carry no further information. On completion it presents the product on `alu_op1` and the accumulate operand on `alu_op2`, so the ALU finishes the instruction with a plain ADD (carry-in 0).

## Interface
- BITS_PER_CYCLE, 8, multiplier bits consumed per busy cycle; legal values are 2, 4, 8. K = 32/BITS_PER_CYCLE is the maximum number of busy cycles.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- start  in  1  launch request; sampled only in IDLE or DONE.
- abort  in  1  cancel (pipeline flush); priority over start.
- mul_long  in  1  1: 64-bit result (xMULL/xMLAL); 0: 32-bit result (MUL/MLA).
- mul_signed  in  1  1: signed operands (long forms only; forced 0 when mul_long=0).
- mul_acc  in  1  1: accumulate.
- rm  in  32  multiplicand.
- rs  in  32  multiplier.
- acc_lo  in  32  accumulate low word (Rn for MLA, RdLo for long forms).
- acc_hi  in  32  accumulate high word (RdHi; ignored when mul_long=0).
- busy  out  1  iteration in progress.
- done  out  1  one-cycle pulse; `alu_op1` and `alu_op2` are valid.
- alu_op1  out  64  product.
- alu_op2  out  64  accumulate operand.

## Operation
- **States:** IDLE, RUN, DONE. Reset puts the block in IDLE with busy=0, done=0, alu_op1=0, alu_op2=0, and clears all internal registers.
- **Launch:**
  - In IDLE or DONE, start=1 with abort=0 latches all operand inputs and moves to RUN.
  - Define rm_ext as rm sign-extended to 64 bits when signed, otherwise zero-extended.
  - The partial-product register P is cleared to 0 and the iteration index i to 0.
- **RUN, iteration i:**
  - chunk = rs[B(i+1)-1 : B·i], always treated as unsigned, where B = BITS_PER_CYCLE.
  - P += (rm_ext × chunk) << (B·i), computed mod 2^64.
  - R = rs >> B(i+1). R is an arithmetic shift when signed and a logical shift when unsigned; at i = K-1, R is 0 or -1 by extension.
- **Termination:**
  - Unsigned: terminate when R == 0.
  - Signed: terminate when R == 0 or R == -1. When R == -1, P -= rm_ext << B(i+1); this correction is applied in the same cycle.
  - Otherwise increment i and stay in RUN. Termination is guaranteed at i = K-1.
- **Completion:**
  - Registers the operand outputs and enters DONE.
    - Long forms: alu_op1 = P; alu_op2 = mul_acc ? {acc_hi,acc_lo} : 0.
    - Short forms: alu_op1 = {32'h0, P[31:0]}; alu_op2 = mul_acc ? {32'h0, acc_lo} : 0.
  - Downstream, result = alu_op1 + alu_op2.
- **DONE:** done=1 for exactly one cycle. From DONE, start=1 relaunches (back-to-back); otherwise the block returns to IDLE.
- **Output hold:** alu_op1 and alu_op2 change only on a completion edge or on reset, and hold their values in IDLE.
- **start while RUN** is ignored; operands are not relatched.
- **abort:** in RUN or DONE, the next state is IDLE with busy=0 and done=0. Outputs are not updated. An abort in the DONE cycle leaves the already-registered outputs intact.
- **reset mid-RUN:** IDLE, with outputs cleared to 0.

## Timing
- Let N be the number of RUN iterations, 1 ≤ N ≤ K.
- start is sampled at edge E0. busy=1 during the N cycles following E0.
- done=1 in the cycle after edge E_N; busy=0 in that cycle.
- Latency from start to done is N+1 edges.
- Sustained throughput is one multiply per N+1 cycles (back-to-back launch from DONE).
- Iteration counts with B=8:
  - rs=0x00000000 → N=1.
  - rs=0x000000FF → N=1.
  - rs=0x00000100 → N=2.
  - rs=0x00010001 → N=3.
  - Unsigned rs=0xFFFFFFFF → N=4.
  - Signed rs=0xFFFFFFFF → N=1.
  - Signed rs=0xFFFFFF00 → N=1.
- busy and done are never high in the same cycle.

## Test plan
- **UMULL:** rm=0xFFFFFFFF, rs=0xFFFFFFFF, mul_acc=0 → N=4, alu_op1=0xFFFFFFFE00000001, alu_op2=0.
- **SMULL, early termination:**
  - rm=0x00000005, rs=0xFFFFFFFF → N=1, alu_op1=0xFFFFFFFFFFFFFFFB.
  - rm=0xFFFFFFFE, rs=0x00000003 → N=1, alu_op1=0xFFFFFFFFFFFFFFFA.
- **MLA:** rm=0x00010000, rs=0x00010001, acc_lo=0x7 → N=3, alu_op1=0x0000000000010000, alu_op2=0x0000000000000007.
- **SMLAL:** rm=0x80000000, rs=0x80000000, acc={0x1,0x2} → N=4, alu_op1=0x4000000000000000, alu_op2=0x0000000100000002.
- **Handshake:**
  - start pulsed during RUN → ignored.
  - start in the DONE cycle → second op busy in the next cycle, with correct result.
  - rs=0 → done two cycles after start.
- **Abort and reset:**
  - abort in the 2nd RUN cycle of a 4-cycle op → IDLE next cycle, no done pulse, outputs equal to the prior result.
  - reset mid-RUN → busy=0, done=0, outputs 0.
